// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the multi-channel serial pattern detector.
//   fill_state_e : classification of a channel's history fill level
//   fill_state() : maps a fill level onto EMPTY/FILLING/ARMED
//   fill_next()  : next fill level after an accepted bit
//   sat_inc()    : saturating increment for a counter of a given width (1..32)
package seq_detect_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } fill_state_e;

    function automatic fill_state_e fill_state(logic [31:0] fill, logic [31:0] fill_max);
        if (fill == 32'd0)
            return EMPTY;
        else if (fill >= fill_max)
            return ARMED;
        else
            return FILLING;
    endfunction

    // Without overlap a match consumes the whole history, so the channel
    // starts collecting from scratch; otherwise the level saturates.
    function automatic logic [31:0] fill_next(logic [31:0] fill, logic match,
                                              logic overlap, logic [31:0] fill_max);
        if (match && !overlap)
            return 32'd0;
        else if (fill < fill_max)
            return fill + 32'd1;
        else
            return fill;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v, int unsigned w);
        logic [31:0] vmax;
        vmax = 32'hFFFF_FFFF >> (32 - w);
        if (v >= vmax)
            return vmax;
        else
            return v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_mealy_if.sv
// Bus between the serial front-end (master) and the detector (slave).
//   clr   : synchronous clear of all channels
//   cen   : per-channel sample enable
//   din   : per-channel serial bit
//   doutx : per-channel combinational match
//   douty : per-channel registered match
//   count : per-channel match counters, channel 0 at the LSBs
interface seq_detect_mealy_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic                      clr;
    logic [CHANNELS-1:0]       cen;
    logic [CHANNELS-1:0]       din;
    logic [CHANNELS-1:0]       doutx;
    logic [CHANNELS-1:0]       douty;
    logic [CHANNELS*CNT_W-1:0] count;

    modport master (output clr, cen, din, input  doutx, douty, count);
    modport slave  (input  clr, cen, din, output doutx, douty, count);
endinterface

// File: rtl/seq_detect_chan.sv
// One detector channel: history shift register, fill level, saturating
// match counter and registered match output.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear (wins over an accepted bit)
//   cen, din   : sample enable and serial bit
//   doutx      : Mealy match, same cycle as the completing bit
//   douty      : doutx registered
//   count      : saturating match count
module seq_detect_chan
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             cen,
    input  logic             din,
    output logic             doutx,
    output logic             douty,
    output logic [CNT_W-1:0] count
);
    localparam int FW = $clog2(PAT_W);
    localparam logic [31:0] FILL_MAX = 32'(PAT_W - 1);

    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;
    fill_state_e      state;
    logic             match;
    logic [31:0]      fill_nx32;
    logic [31:0]      cnt_nx32;

    // window doubles as the candidate match and the shifted history
    assign window = {hist, din};
    assign state  = fill_state(32'(fill), FILL_MAX);
    assign match  = cen & ~clr & ~reset & (state == ARMED) & (window == PATTERN);
    assign doutx  = match;

    always_comb begin
        fill_nx32 = fill_next(32'(fill), match, OVERLAP != 0, FILL_MAX);
        cnt_nx32  = sat_inc(32'(count), CNT_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            count <= '0;
            douty <= 1'b0;
        end else begin
            douty <= match;
            if (clr) begin
                hist  <= '0;
                fill  <= '0;
                count <= '0;
            end else if (cen) begin
                hist <= window[PAT_W-2:0];
                fill <= fill_nx32[FW-1:0];
                if (match)
                    count <= cnt_nx32[CNT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/seq_detect_mealy.sv
// Multi-channel serial pattern detector. Each channel independently
// watches its own serial stream for PATTERN (MSB received first).
//   clk, reset : clock, async active-high reset
//   bus        : slave side of seq_detect_mealy_if (clr/cen/din in,
//                doutx/douty/count out)
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int               CHANNELS = 2,
    parameter int               PAT_W    = 3,
    parameter logic [PAT_W-1:0] PATTERN  = 3'b101,
    parameter int               OVERLAP  = 1,
    parameter int               CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_mealy_if.slave  bus
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        seq_detect_chan #(
            .PAT_W   (PAT_W),
            .PATTERN (PATTERN),
            .OVERLAP (OVERLAP),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.clr),
            .cen   (bus.cen[i]),
            .din   (bus.din[i]),
            .doutx (bus.doutx[i]),
            .douty (bus.douty[i]),
            .count (bus.count[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus bus; each vector selects which
// instance is compared.
module tb_seq_detect_mealy;
    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [1:0] cen, din;
    logic [1:0] sel;

    always #5 clk = ~clk;

    seq_detect_mealy_if #(.CHANNELS(2), .CNT_W(8)) ifa ();
    seq_detect_mealy_if #(.CHANNELS(2), .CNT_W(8)) ifb ();
    seq_detect_mealy_if #(.CHANNELS(2), .CNT_W(2)) ifc ();

    assign ifa.clr = clr; assign ifa.cen = cen; assign ifa.din = din;
    assign ifb.clr = clr; assign ifb.cen = cen; assign ifb.din = din;
    assign ifc.clr = clr; assign ifc.cen = cen; assign ifc.din = din;

    seq_detect_mealy #(.CHANNELS(2), .PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    seq_detect_mealy #(.CHANNELS(2), .PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    seq_detect_mealy #(.CHANNELS(2), .PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [1:0] sx, sy;
    logic [7:0] sc0, sc1;
    always_comb begin
        sx = ifa.doutx; sy = ifa.douty;
        sc0 = ifa.count[7:0]; sc1 = ifa.count[15:8];
        case (sel)
            2'd1: begin
                sx = ifb.doutx; sy = ifb.douty;
                sc0 = ifb.count[7:0]; sc1 = ifb.count[15:8];
            end
            2'd2: begin
                sx = ifc.doutx; sy = ifc.douty;
                sc0 = {6'd0, ifc.count[1:0]}; sc1 = {6'd0, ifc.count[3:2]};
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0] sel;
        logic       clr;
        logic [1:0] cen;
        logic [1:0] din;
        logic [1:0] ex_x;
        logic [7:0] ex_c0;
        logic [7:0] ex_c1;
    } vec_t;

    vec_t       vt[$];
    logic [1:0] sbq[$];
    int         tests  = 0;
    int         failed = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] s, input logic c, input logic [1:0] e,
                                input logic [1:0] d, input logic [1:0] x,
                                input logic [7:0] c0, input logic [7:0] c1);
        vec_t v;
        v.sel = s; v.clr = c; v.cen = e; v.din = d; v.ex_x = x; v.ex_c0 = c0; v.ex_c1 = c1;
        return v;
    endfunction

    // Drive one vector, check the Mealy output before the edge, then the
    // registered output (from the scoreboard) and counters after it.
    task automatic step(input int idx, input vec_t v);
        logic [1:0] e;
        sel = v.sel; clr = v.clr; cen = v.cen; din = v.din;
        #1;
        chk($sformatf("v%0d doutx", idx), {6'd0, sx}, {6'd0, v.ex_x});
        sbq.push_back(v.ex_x);
        @(posedge clk); #1;
        if (sbq.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 8'd1, 8'd0);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d douty", idx), {6'd0, sy}, {6'd0, e});
        end
        chk($sformatf("v%0d count0", idx), sc0, v.ex_c0);
        chk($sformatf("v%0d count1", idx), sc1, v.ex_c1);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; cen = 2'b00; din = 2'b00; sel = 2'd0;

        // overlap: 1,0,1,0,1 on ch0, ch1 disabled
        vt.push_back(mk(0, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b11, 2'b01, 1, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b11, 2'b01, 2, 0));
        // non-overlap: 1,0,1,0,1,0,1 -> matches on bits 3 and 7
        vt.push_back(mk(1, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b01, 2'b01, 1, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b00, 2'b00, 1, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b01, 2'b00, 1, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b00, 2'b00, 1, 0));
        vt.push_back(mk(1, 0, 2'b01, 2'b01, 2'b01, 2, 0));
        // enable gaps: 1/1, 1/0, 0/1, 0/0, 1/1
        vt.push_back(mk(0, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
        // saturation with a 2-bit counter: 5 matches, count 1,2,3,3,3
        vt.push_back(mk(2, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b01, 1, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b00, 2'b00, 1, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b01, 2, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b00, 2'b00, 2, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b01, 3, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b00, 2'b00, 3, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b01, 3, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b00, 2'b00, 3, 0));
        vt.push_back(mk(2, 0, 2'b01, 2'b01, 2'b01, 3, 0));
        // clr arriving with the completing bit blocks the match
        vt.push_back(mk(0, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 1, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
        // channel independence: ch1 lags ch0 by one cycle
        vt.push_back(mk(0, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b11, 2'b10, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b11, 2'b01, 2'b01, 1, 0));
        vt.push_back(mk(0, 0, 2'b10, 2'b10, 2'b10, 1, 1));
        // lead-in for the async reset sequence: 1,0,1,0
        vt.push_back(mk(0, 1, 2'b11, 2'b11, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b01, 2'b01, 1, 0));
        vt.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 0));

        // reset state of all three instances
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0.1;
            chk($sformatf("rst%0d doutx", s), {6'd0, sx}, 8'd0);
            chk($sformatf("rst%0d douty", s), {6'd0, sy}, 8'd0);
            chk($sformatf("rst%0d count0", s), sc0, 8'd0);
            chk($sformatf("rst%0d count1", s), sc1, 8'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++)
            step(i, vt[i]);

        // history is 1,0 and armed: a 1 completes the pattern, until reset
        sel = 2'd0; clr = 1'b0; cen = 2'b01; din = 2'b01;
        #1;
        chk("pre-reset doutx", {6'd0, sx}, 8'd1);
        reset = 1'b1;
        #1;
        chk("reset doutx", {6'd0, sx}, 8'd0);
        chk("reset douty", {6'd0, sy}, 8'd0);
        chk("reset count0", sc0, 8'd1 - 8'd1);
        #1;
        reset = 1'b0;
        // the partial pattern is gone, so the same 1 no longer matches
        step(1000, mk(0, 0, 2'b01, 2'b01, 2'b00, 0, 0));
        step(1001, mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0));

        chk("scoreboard drained", 8'(sbq.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
